delay_drain_buffer: RTL and testbench

Receive-side companion to the fixed-latency delay line used throughout the NTT datapath. Fixed pipelines built from non-resettable delay stages cannot stall, so every result they emit must be stored when it appears. This block sits at the output end of such a pipeline. It buffers results into a FIFO, presents them to a downstream consumer with valid/ready backpressure, and issues credits to the upstream launcher so that the buffer never overflows.

---
 rtl/delay_drain_buffer.sv | 72 +++++++
 tb/tb_delay_drain_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_drain_buffer.sv
// delay_drain_buffer: credit-managed FIFO that catches every result of a fixed-latency,
// non-stallable pipeline and hands it to a valid/ready consumer.
module delay_drain_buffer #(
  parameter int DELAY = 4,
  parameter int LOGQ  = 16,
  parameter int DEPTH = DELAY + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       pipe_valid,
  input  logic [LOGQ-1:0]            pipe_data,
  output logic                       out_valid,
  output logic [LOGQ-1:0]            out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DELAY + 1);
  typedef enum logic {FLUSH, RUN} state_t;
  state_t          r_state;
  logic [FW-1:0]   r_flush;
  logic [CW-1:0]   r_credits;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [LOGQ-1:0] r_mem [DEPTH];
  logic            r_err;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_drop;
  assign w_full      = r_count == CW'(DEPTH);
  assign w_pop       = (r_count != '0) && out_ready;
  // a full buffer still accepts a write when the head leaves in the same cycle
  assign w_push      = (r_state == RUN) && pipe_valid && (!w_full || w_pop);
  assign w_drop      = (r_state == RUN) && pipe_valid && w_full && !w_pop;
  assign issue_ready = (r_state == RUN) && (r_credits != '0);
  assign w_issue     = issue_valid && issue_ready;
  assign out_valid   = r_count != '0;
  assign out_data    = r_mem[r_rp];
  assign count       = r_count;
  assign err         = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FLUSH;
      r_flush   <= FW'(DELAY);
      r_credits <= CW'(DEPTH);
      r_count   <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == FLUSH) begin
        r_flush <= r_flush - 1'b1;
        r_state <= r_flush <= FW'(1) ? RUN : FLUSH;
      end
      r_credits <= r_credits + CW'(w_pop) - CW'(w_issue);
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
      if ((issue_valid && !issue_ready) || w_drop) r_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= pipe_data;
  end
endmodule

// File: tb/tb_delay_drain_buffer.sv
// tb_delay_drain_buffer: random and directed stimulus with an external pipeline model;
// a scoreboard queue holds the expected buffer contents and a negedge monitor checks them.
module tb_delay_drain_buffer;
  localparam int DELAY = 4;
  localparam int LOGQ  = 16;
  localparam int DEPTH = DELAY + 1;
  logic clk = 0;
  logic rst = 1;
  logic issue_valid = 0;
  logic issue_ready;
  logic pipe_valid;
  logic [LOGQ-1:0] pipe_data;
  logic out_valid;
  logic [LOGQ-1:0] out_data;
  logic out_ready = 0;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic err;
  delay_drain_buffer #(.DELAY(DELAY), .LOGQ(LOGQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .count(count), .err(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [LOGQ-1:0] iss_d = 0;
  logic f_pv = 0;
  logic [LOGQ-1:0] f_pd = 0;
  logic sh_v [DELAY] = '{default: 1'b0};
  logic [LOGQ-1:0] sh_d [DELAY] = '{default: '0};
  assign pipe_valid = sh_v[DELAY-1] | f_pv;
  assign pipe_data  = f_pv ? f_pd : sh_d[DELAY-1];
  logic [LOGQ-1:0] exp_q [$];
  bit started = 0;
  bit m_run = 0;
  bit m_ir = 0;
  bit m_err = 0;
  bit m_pop = 0;
  int m_fc = 0;
  int m_cred = 0;
  always @(posedge clk) begin
    automatic bit launch = issue_valid && m_ir;
    if (rst) begin
      started = 1;
      m_run = 0;
      m_fc = DELAY;
      m_cred = DEPTH;
      m_err = 0;
      exp_q.delete();
    end else if (started) begin
      if (issue_valid && !m_ir) m_err = 1;
      if (m_run && pipe_valid) begin
        if (exp_q.size() == DEPTH) m_err = 1;
        else exp_q.push_back(pipe_data);
      end
      m_cred = m_cred + (m_pop ? 1 : 0) - (launch ? 1 : 0);
      if (!m_run) begin
        m_fc--;
        if (m_fc == 0) m_run = 1;
      end
    end
    m_ir = m_run && m_cred != 0;
    for (int i = DELAY - 1; i > 0; i--) begin
      sh_v[i] <= sh_v[i-1];
      sh_d[i] <= sh_d[i-1];
    end
    sh_v[0] <= launch;
    sh_d[0] <= iss_d;
  end
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), exp_q.size());
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("issue_ready", 32'(issue_ready), 32'(m_ir));
      chk("err", 32'(err), 32'(m_err));
      m_pop = exp_q.size() != 0 && out_ready;
      if (m_pop) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end
  int seq = 0;
  bit use_rand = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic issue_n(int n);
    int k = 0;
    for (int c = 0; c < 50 && k < n; c++) begin
      issue_valid = m_ir;
      iss_d = use_rand ? LOGQ'($urandom) : LOGQ'(seq + 1);
      tick();
      if (issue_valid) begin
        k++;
        seq++;
      end
    end
    issue_valid = 0;
    chk("issue_n_done", k, n);
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    ticks(DELAY + 1);
  endtask
  initial begin
    ticks(2);
    chk("rst_ready", 32'(issue_ready), 0);
    rst = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("flush_ready", 32'(issue_ready), 32'(i >= DELAY));
    end
    out_ready = 1;
    issue_n(8);
    ticks(DELAY + 4);
    chk("stream_empty", 32'(count), 0);
    out_ready = 0;
    issue_n(DEPTH);
    chk("bp_ready", 32'(issue_ready), 0);
    ticks(DELAY + 1);
    chk("bp_count", 32'(count), DEPTH);
    out_ready = 1;
    tick();
    chk("bp_credit_back", 32'(issue_ready), 1);
    ticks(DEPTH + 2);
    out_ready = 0;
    issue_n(2);
    ticks(DELAY + 1);
    issue_n(2);
    issue_valid = m_ir;
    out_ready = 1;
    tick();
    issue_valid = 0;
    out_ready = 0;
    chk("sim_count", 32'(count), 1);
    chk("sim_ready", 32'(issue_ready), 1);
    ticks(DELAY + 1);
    out_ready = 1;
    ticks(DEPTH + 2);
    out_ready = 0;
    issue_n(DEPTH);
    ticks(DELAY + 1);
    f_pv = 1;
    f_pd = 16'h1234;
    out_ready = 1;
    tick();
    f_pv = 0;
    out_ready = 0;
    chk("full_pop_count", 32'(count), DEPTH);
    chk("full_pop_err", 32'(err), 0);
    out_ready = 1;
    ticks(DEPTH + 3);
    out_ready = 0;
    do_reset();
    issue_n(DEPTH);
    ticks(DELAY + 1);
    f_pv = 1;
    f_pd = 16'hBEEF;
    tick();
    f_pv = 0;
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(count), DEPTH);
    out_ready = 1;
    ticks(DEPTH + 3);
    chk("ovf_err_sticky", 32'(err), 1);
    out_ready = 0;
    do_reset();
    issue_n(DEPTH);
    ticks(2);
    chk("mid_count", 32'(count), 3);
    rst = 1;
    tick();
    rst = 0;
    f_pv = 1;
    for (int i = 1; i <= DELAY; i++) begin
      f_pd = LOGQ'($urandom);
      tick();
      chk("mid_ready", 32'(issue_ready), 32'(i == DELAY));
    end
    f_pv = 0;
    chk("mid_count0", 32'(count), 0);
    chk("mid_valid0", 32'(out_valid), 0);
    chk("mid_err0", 32'(err), 0);
    use_rand = 1;
    for (int c = 0; c < 800; c++) begin
      rst = $urandom_range(0, 299) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      issue_valid = m_ir && $urandom_range(0, 1) == 1;
      iss_d = LOGQ'($urandom);
      tick();
    end
    rst = 0;
    issue_valid = 0;
    out_ready = 1;
    ticks(DELAY + DEPTH + 4);
    chk("final_empty", 32'(count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
